// File: rtl/tile_fill_writer.sv
// Rectangle-fill write engine for the tile framebuffer: accepts a fill command in
// tile coordinates and streams one raster-ordered write per clock to the memory write port.
module tile_fill_writer #(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 60,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK,
  input  logic              CPU_RESETN,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [6:0]        X0,
  input  logic [5:0]        Y0,
  input  logic [6:0]        X1,
  input  logic [5:0]        Y1,
  input  logic [DATA_W-1:0] COLOR,
  output logic              WE,
  output logic [ADDR_W-1:0] WADDR,
  output logic [DATA_W-1:0] WDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam int unsigned XW = 7;
  localparam int unsigned YW = 6;
  localparam logic [XW-1:0]     COL_LIM   = XW'(COLS);
  localparam logic [YW-1:0]     ROW_LIM   = YW'(ROWS);
  localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(COLS);

  typedef enum logic [0:0] {S_IDLE, S_FILL} state_t;

  state_t state_q, state_d;

  logic [XW-1:0]     col_q, col_d;
  logic [YW-1:0]     row_q, row_d;
  logic [XW-1:0]     x0_q, x0_d;
  logic [XW-1:0]     x1_q, x1_d;
  logic [YW-1:0]     y1_q, y1_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;

  logic              we_d, done_d, err_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [DATA_W-1:0] wdata_d;

  logic accept;
  logic cmd_ok;
  logic row_end;
  logic last;

  // Constant multiply by COLS as a sum of shifted copies of y (no multiplier).
  function automatic logic [ADDR_W-1:0] mul_cols(input logic [YW-1:0] y);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (COLS[i]) acc = acc + (ADDR_W'(y) << i);
    end
    return acc;
  endfunction

  assign CMD_READY = (state_q == S_IDLE);
  assign BUSY      = (state_q == S_FILL);

  assign accept  = CMD_VALID && (state_q == S_IDLE);
  assign cmd_ok  = (X0 <= X1) && (X1 < COL_LIM) && (Y0 <= Y1) && (Y1 < ROW_LIM);
  assign row_end = (col_q == x1_q);
  assign last    = row_end && (row_q == y1_q);

  // State register
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && cmd_ok) state_d = S_FILL;
      S_FILL:  if (last)             state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  // Next values for the walk counters and the registered write port
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    row_base_d = row_base_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    waddr_d    = WADDR;
    wdata_d    = WDATA;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_ok) begin
            x0_d       = X0;
            x1_d       = X1;
            y1_d       = Y1;
            col_d      = X0;
            row_d      = Y0;
            row_base_d = mul_cols(Y0);
            waddr_d    = row_base_d + ADDR_W'(X0);
            wdata_d    = COLOR;
            we_d       = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (last) begin
          done_d = 1'b1;
        end else begin
          if (row_end) begin
            col_d      = x0_q;
            row_d      = row_q + YW'(1);
            row_base_d = row_base_q + ROW_PITCH;
          end else begin
            col_d = col_q + XW'(1);
          end
          waddr_d = row_base_d + ADDR_W'(col_d);
          we_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; WE clears asynchronously on reset
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      col_q      <= '0;
      row_q      <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      row_base_q <= '0;
      WE         <= 1'b0;
      WADDR      <= '0;
      WDATA      <= '0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      row_base_q <= row_base_d;
      WE         <= we_d;
      WADDR      <= waddr_d;
      WDATA      <= wdata_d;
      DONE       <= done_d;
      ERR        <= err_d;
    end
  end

endmodule

// File: tb/tb_tile_fill_writer.sv
// Randomised self-checking bench for tile_fill_writer against a raster-walk
// model and a shadow copy of the framebuffer.
module tb_tile_fill_writer;

  localparam int COLS = 80;
  localparam int ROWS = 60;
  localparam int NT   = COLS * ROWS;

  logic        CLK = 1'b0;
  logic        CPU_RESETN = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [6:0]  X0 = '0;
  logic [5:0]  Y0 = '0;
  logic [6:0]  X1 = '0;
  logic [5:0]  Y1 = '0;
  logic [7:0]  COLOR = '0;
  logic        WE;
  logic [12:0] WADDR;
  logic [7:0]  WDATA;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  tile_fill_writer #(.COLS(80), .ROWS(60), .ADDR_W(13), .DATA_W(8)) dut (
    .CLK(CLK), .CPU_RESETN(CPU_RESETN), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .X0(X0), .Y0(Y0), .X1(X1), .Y1(Y1), .COLOR(COLOR),
    .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;

  // Observations collected at every falling edge
  int        obs_addr[$];
  logic [7:0] obs_data[$];
  time       obs_t[$];
  time       done_t[$];
  int        err_cnt, busy_cnt, rdy_low, done_nrdy;
  logic [7:0] dut_mem[NT];
  logic [7:0] ref_mem[NT];

  initial begin
    for (int i = 0; i < NT; i++) begin
      dut_mem[i] = '0;
      ref_mem[i] = '0;
    end
  end

  always @(negedge CLK) begin
    if (CPU_RESETN) begin
      if (WE) begin
        obs_addr.push_back(int'(WADDR));
        obs_data.push_back(WDATA);
        obs_t.push_back($time);
        if (int'(WADDR) < NT) dut_mem[int'(WADDR)] = WDATA;
      end
      if (DONE) begin
        done_t.push_back($time);
        if (!CMD_READY) done_nrdy++;
      end
      if (ERR) err_cnt++;
      if (BUSY) busy_cnt++;
      if (!CMD_READY) rdy_low++;
    end
  end

  task automatic clear_mon();
    obs_addr.delete();
    obs_data.delete();
    obs_t.delete();
    done_t.delete();
    err_cnt = 0; busy_cnt = 0; rdy_low = 0; done_nrdy = 0;
  endtask

  task automatic set_cmd(input int x0, input int y0, input int x1, input int y1, input int c);
    X0 = 7'(x0); Y0 = 6'(y0); X1 = 7'(x1); Y1 = 6'(y1); COLOR = 8'(c);
  endtask

  task automatic wait_done(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge CLK);
      if (DONE) seen = 1'b1;
    end
  endtask

  function automatic int mem_diff();
    int d = 0;
    for (int i = 0; i < NT; i++) if (dut_mem[i] !== ref_mem[i]) d++;
    return d;
  endfunction

  task automatic do_fill(input int x0, input int y0, input int x1, input int y1,
                         input int c, input string tag);
    int  exp_a[$];
    int  n, bad_a, bad_d, bad_t, d;
    time t_acc;
    bit  seen;
    clear_mon();
    @(negedge CLK);
    set_cmd(x0, y0, x1, y1, c);
    CMD_VALID = 1'b1;
    @(posedge CLK);
    t_acc = $time;
    #1 CMD_VALID = 1'b0;
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) exp_a.push_back(y * COLS + x);
    n = exp_a.size();
    wait_done(n + 5, seen);
    #1;
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL %s done_timeout: no DONE within %0d cycles", tag, n + 5);
    end
    compared++;
    if (obs_addr.size() != n) begin
      mismatched++;
      $display("FAIL %s write_count: got %0d expected %0d", tag, obs_addr.size(), n);
    end
    bad_a = 0; bad_d = 0; bad_t = 0;
    for (int i = 0; i < n && i < obs_addr.size(); i++) begin
      if (obs_addr[i] != exp_a[i]) bad_a++;
      if (obs_data[i] !== 8'(c)) bad_d++;
      if (obs_t[i] != t_acc + 5 + 10 * i) bad_t++;
    end
    compared++;
    if (bad_a != 0) begin
      mismatched++;
      $display("FAIL %s addr_seq: %0d wrong addresses, first got %0d expected %0d",
               tag, bad_a, (obs_addr.size() > 0) ? obs_addr[0] : -1, exp_a[0]);
    end
    compared++;
    if (bad_d != 0) begin
      mismatched++;
      $display("FAIL %s wdata: %0d writes with wrong data, expected %02h", tag, bad_d, 8'(c));
    end
    compared++;
    if (bad_t != 0) begin
      mismatched++;
      $display("FAIL %s write_timing: %0d writes off the 1-cycle-latency gapless schedule", tag, bad_t);
    end
    compared++;
    if (done_t.size() != 1 || done_t[0] != t_acc + 5 + 10 * n) begin
      mismatched++;
      $display("FAIL %s done_pulse: got %0d pulses (first at %0t) expected 1 at %0t",
               tag, done_t.size(), (done_t.size() > 0) ? done_t[0] : 0, t_acc + 5 + 10 * n);
    end
    compared++;
    if (busy_cnt != n || done_nrdy != 0) begin
      mismatched++;
      $display("FAIL %s busy_ready: busy cycles %0d expected %0d, DONE without READY %0d expected 0",
               tag, busy_cnt, n, done_nrdy);
    end
    foreach (exp_a[i]) ref_mem[exp_a[i]] = 8'(c);
    d = mem_diff();
    compared++;
    if (d != 0) begin
      mismatched++;
      $display("FAIL %s memory: %0d bytes differ from model, expected 0", tag, d);
    end
  endtask

  task automatic test_reset();
    #1;
    compared++;
    if (WE !== 1'b0 || WADDR !== 13'd0 || WDATA !== 8'd0) begin
      mismatched++;
      $display("FAIL reset_port: WE=%b WADDR=%0d WDATA=%02h expected 0/0/00", WE, WADDR, WDATA);
    end
    compared++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_flags: BUSY=%b DONE=%b ERR=%b expected 0/0/0", BUSY, DONE, ERR);
    end
    compared++;
    if (CMD_READY !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: CMD_READY=%b expected 1", CMD_READY);
    end
    #20 CPU_RESETN = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_first_cmd();
    do_fill(2, 3, 4, 3, 'hE0, "row3");
    compared++;
    if (CMD_READY !== 1'b1 || BUSY !== 1'b0) begin
      mismatched++;
      $display("FAIL row3_idle: CMD_READY=%b BUSY=%b expected 1/0", CMD_READY, BUSY);
    end
  endtask

  task automatic test_corner_column();
    do_fill(79, 58, 79, 59, 'h1C, "corner");
    compared++;
    if (obs_addr.size() != 2 || obs_addr[0] != 4719 || obs_addr[1] != 4799) begin
      mismatched++;
      $display("FAIL corner_addrs: got %0d writes, expected 4719 then 4799", obs_addr.size());
    end
  endtask

  task automatic test_full_screen();
    int steps_bad = 0;
    do_fill(0, 0, 79, 59, 'h03, "full");
    for (int i = 1; i < obs_addr.size(); i++)
      if (obs_addr[i] != obs_addr[i-1] + 1) steps_bad++;
    compared++;
    if (steps_bad != 0 || obs_addr.size() != NT || obs_addr[0] != 0) begin
      mismatched++;
      $display("FAIL full_increment: %0d non-unit steps over %0d writes, expected 0 over %0d",
               steps_bad, obs_addr.size(), NT);
    end
  endtask

  task automatic test_invalid();
    int inv[3][4] = '{'{5, 0, 4, 0}, '{0, 0, 80, 0}, '{0, 0, 0, 60}};
    clear_mon();
    @(negedge CLK);
    set_cmd(inv[0][0], inv[0][1], inv[0][2], inv[0][3], 'hFF);
    CMD_VALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      if (k < 2) set_cmd(inv[k+1][0], inv[k+1][1], inv[k+1][2], inv[k+1][3], 'hFF);
      else       CMD_VALID = 1'b0;
      @(negedge CLK);
      compared++;
      if (ERR !== 1'b1 || WE !== 1'b0 || CMD_READY !== 1'b1) begin
        mismatched++;
        $display("FAIL invalid_%0d: ERR=%b WE=%b CMD_READY=%b expected 1/0/1", k, ERR, WE, CMD_READY);
      end
    end
    @(negedge CLK);
    compared++;
    if (ERR !== 1'b0) begin
      mismatched++;
      $display("FAIL invalid_err_clear: ERR=%b expected 0", ERR);
    end
    #1;
    compared++;
    if (err_cnt != 3 || obs_addr.size() != 0 || rdy_low != 0 || busy_cnt != 0) begin
      mismatched++;
      $display("FAIL invalid_totals: err=%0d writes=%0d ready_low=%0d busy=%0d expected 3/0/0/0",
               err_cnt, obs_addr.size(), rdy_low, busy_cnt);
    end
    compared++;
    if (mem_diff() != 0) begin
      mismatched++;
      $display("FAIL invalid_memory: %0d bytes differ, expected 0", mem_diff());
    end
  endtask

  task automatic test_back_to_back();
    int  exp_a[$];
    int  na, nb, bad;
    time t_a, t_b;
    bit  seen;
    clear_mon();
    for (int y = 1; y <= 2; y++) for (int x = 1; x <= 3; x++) exp_a.push_back(y * COLS + x);
    na = exp_a.size();
    for (int y = 50; y <= 51; y++) for (int x = 70; x <= 72; x++) exp_a.push_back(y * COLS + x);
    nb = exp_a.size() - na;
    @(negedge CLK);
    set_cmd(1, 1, 3, 2, 'h5A);
    CMD_VALID = 1'b1;
    @(posedge CLK);
    t_a = $time;
    #1 set_cmd(70, 50, 72, 51, 'hA5);
    wait_done(na + 5, seen);
    @(posedge CLK);
    t_b = $time;
    #1 CMD_VALID = 1'b0;
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL b2b_first_done: no DONE within %0d cycles", na + 5);
    end
    wait_done(nb + 5, seen);
    #1;
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL b2b_second_done: no DONE within %0d cycles", nb + 5);
    end
    bad = 0;
    for (int i = 0; i < exp_a.size() && i < obs_addr.size(); i++) begin
      if (obs_addr[i] != exp_a[i]) bad++;
      if (obs_data[i] !== ((i < na) ? 8'h5A : 8'hA5)) bad++;
    end
    compared++;
    if (bad != 0 || obs_addr.size() != na + nb) begin
      mismatched++;
      $display("FAIL b2b_writes: %0d bad writes, %0d total expected %0d", bad, obs_addr.size(), na + nb);
    end
    compared++;
    if (obs_t.size() != na + nb || obs_t[na] != obs_t[na-1] + 20 || t_b != t_a + 10 * (na + 1)) begin
      mismatched++;
      $display("FAIL b2b_gap: second accept at %0t expected %0t", t_b, t_a + 10 * (na + 1));
    end
    compared++;
    if (done_t.size() != 2 || done_t[1] != t_b + 5 + 10 * nb) begin
      mismatched++;
      $display("FAIL b2b_done: %0d DONE pulses, expected 2", done_t.size());
    end
    foreach (exp_a[i]) ref_mem[exp_a[i]] = (i < na) ? 8'h5A : 8'hA5;
  endtask

  task automatic test_reset_mid_fill();
    int exp_a[$];
    int bad;
    clear_mon();
    for (int y = 20; y <= 23; y++) for (int x = 10; x <= 13; x++) exp_a.push_back(y * COLS + x);
    @(negedge CLK);
    set_cmd(10, 20, 13, 23, 'h77);
    CMD_VALID = 1'b1;
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
    #91 CPU_RESETN = 1'b0;
    #1;
    compared++;
    if (WE !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || CMD_READY !== 1'b1) begin
      mismatched++;
      $display("FAIL midreset_async: WE=%b BUSY=%b DONE=%b READY=%b expected 0/0/0/1",
               WE, BUSY, DONE, CMD_READY);
    end
    repeat (2) @(negedge CLK);
    #2 CPU_RESETN = 1'b1;
    @(negedge CLK);
    #1;
    bad = 0;
    for (int i = 0; i < obs_addr.size() && i < 9; i++) if (obs_addr[i] != exp_a[i]) bad++;
    compared++;
    if (obs_addr.size() != 9 || bad != 0 || done_t.size() != 0 || err_cnt != 0) begin
      mismatched++;
      $display("FAIL midreset_partial: writes=%0d bad=%0d done=%0d err=%0d expected 9/0/0/0",
               obs_addr.size(), bad, done_t.size(), err_cnt);
    end
    for (int i = 0; i < 9; i++) ref_mem[exp_a[i]] = 8'h77;
    do_fill(40, 30, 40, 30, 'h99, "post_reset_1x1");
  endtask

  task automatic test_random();
    int x0, y0, x1, y1;
    for (int k = 0; k < 6; k++) begin
      x0 = $urandom_range(COLS - 1);
      y0 = $urandom_range(ROWS - 1);
      x1 = x0 + $urandom_range(5);
      y1 = y0 + $urandom_range(3);
      if (x1 > COLS - 1) x1 = COLS - 1;
      if (y1 > ROWS - 1) y1 = ROWS - 1;
      do_fill(x0, y0, x1, y1, $urandom_range(255), $sformatf("rand%0d", k));
    end
  endtask

  initial begin
    test_reset();
    test_first_cmd();
    test_corner_column();
    test_invalid();
    test_back_to_back();
    test_random();
    test_full_screen();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/tile_fill_writer.md
Name: tile_fill_writer

Overview:
- Write-side engine for the 80x60 tile framebuffer (one 8-bit RRRGGGBB byte per 8x8 tile, linear address = row*80 + col).
- Accepts a rectangle-fill command in tile coordinates and issues one framebuffer write per clock, in raster order, until the rectangle is filled.
- Drives the write port of the same dual-port memory whose read port is scanned by the VGA display path.

Parameters:
- COLS, 80, tiles per row.
- ROWS, 60, tiles per column.
- ADDR_W, 13, framebuffer address width; must satisfy 2^ADDR_W >= COLS*ROWS.
- DATA_W, 8, colour byte width.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- CPU_RESETN  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  engine can accept a command.
- X0  in  7  left column, inclusive.
- Y0  in  6  top row, inclusive.
- X1  in  7  right column, inclusive.
- Y1  in  6  bottom row, inclusive.
- COLOR  in  DATA_W  fill byte.
- WE  out  1  framebuffer write enable.
- WADDR  out  ADDR_W  framebuffer write address.
- WDATA  out  DATA_W  framebuffer write data.
- BUSY  out  1  fill in progress.
- DONE  out  1  one-cycle pulse: fill finished.
- ERR  out  1  one-cycle pulse: command rejected.

Behaviour:
- Reset (CPU_RESETN low, asynchronous):
  - State = IDLE.
  - WE=0, WADDR=0, WDATA=0, BUSY=0, DONE=0, ERR=0.
  - CMD_READY=1, since it is decoded as state==IDLE.
- States: IDLE, FILL. CMD_READY = (state==IDLE). BUSY = (state==FILL).
- Handshake: a command is accepted on a rising edge where CMD_VALID && CMD_READY. X0/Y0/X1/Y1/COLOR are sampled on that edge only. Inputs are ignored in FILL.
- Validation on acceptance. The command is valid iff X0<=X1, X1<COLS, Y0<=Y1 and Y1<ROWS.
  - Invalid: ERR=1 for the next cycle only. State stays IDLE and no write is issued. CMD_READY stays 1, so a new command may be accepted on the same edge ERR is high.
  - Valid: go to FILL. Latch COLOR into WDATA.
- FILL:
  - The first write (WE=1, WADDR=Y0*COLS+X0) appears in the cycle after acceptance, so latency is 1 cycle.
  - Traversal is raster order: column increments from X0 to X1; then column resets to X0 and the row advances.
  - WE is high every cycle in FILL with no gaps. Total writes = (X1-X0+1)*(Y1-Y0+1), one per cycle.
- Address arithmetic:
  - No multiplier. A row_base register is loaded with Y0*COLS at acceptance. Because COLS is a constant, this is a constant multiply realised as shifts and adds (80 = 64+16).
  - row_base += COLS at the end of each row. WADDR = row_base + col.
  - All values are registered; the maximum address is COLS*ROWS-1 = 4799.
- Completion: the last write cycle is column X1 and row Y1. On that edge:
  - State goes to IDLE and WE drops to 0.
  - DONE=1 for exactly one cycle, coincident with CMD_READY=1.
  - WADDR and WDATA hold their last values; they are don't-care while WE=0.
- Boundary cases:
  - Single-tile rectangle (X0=X1, Y0=Y1): exactly 1 write cycle, then DONE.
  - Single row or single column: no row-advance glitch; addresses stay contiguous or step by COLS.
  - Full screen (0,0)-(79,59): 4800 writes, covering addresses 0..4799 once each.
  - A command held valid across DONE is accepted on the DONE cycle. Its first write follows with no idle cycle beyond the DONE cycle.
- Reset mid-fill: WE drops immediately (asynchronously) and the fill is abandoned. There is no DONE or ERR. The partial rectangle remains in memory.

Test Plan:
- Reset release, then CMD (X0=2,Y0=3,X1=4,Y1=3,COLOR=E0) -> after 1 cycle WE=1 for 3 cycles with WADDR 242, 243, 244 and WDATA=E0; DONE pulses on the next cycle; CMD_READY=1.
- CMD (X0=79,Y0=58,X1=79,Y1=59,COLOR=1C) -> 2 writes at 4719 and 4799, then DONE; no other WE.
- Full screen, COLOR=03 -> exactly 4800 WE cycles, addresses 0..4799 strictly increasing by 1; BUSY high for 4800 cycles; one DONE.
- Invalid commands X0=5,X1=4 / X1=80 / Y1=60 -> ERR one cycle each, zero WE, CMD_READY never drops; the bench's memory model is unchanged.
- Back-to-back: second command held valid during the first fill -> accepted on the DONE cycle; its first WE on the next cycle; CMD_VALID during FILL produces no acceptance.
- Assert CPU_RESETN low on write 10 of a 4x4 fill -> WE=0 within the same cycle, BUSY=0, no DONE; after release a new 1x1 command completes normally.
